// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - Wishbone N-master to 1-slave arbiter; define WBARB_ROUND_ROBIN_EN for round robin, else fixed priority
module wb_rr_arbiter #(
   parameter int NMASTER = 4,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [NMASTER-1:0]        m_cyc,
   input  logic [NMASTER-1:0]        m_stb,
   input  logic [NMASTER-1:0]        m_we,
   input  logic [NMASTER*AW-1:0]     m_addr,
   input  logic [NMASTER*DW-1:0]     m_data,
   input  logic [NMASTER*(DW/8)-1:0] m_sel,
   output logic [NMASTER-1:0]        m_stall,
   output logic [NMASTER-1:0]        m_ack,
   output logic [NMASTER-1:0]        m_err,
   output logic                      o_cyc,
   output logic                      o_stb,
   output logic                      o_we,
   output logic [AW-1:0]             o_addr,
   output logic [DW-1:0]             o_data,
   output logic [DW/8-1:0]           o_sel,
   input  logic                      o_stall,
   input  logic                      o_ack,
   input  logic                      o_err,
   output logic                      gnt_valid,
   output logic [2:0]                gnt_idx,
   output logic [3:0]                outstanding
);

   localparam int SW = DW / 8;

   typedef enum logic {ST_IDLE = 1'b0, ST_OWNED = 1'b1} state_t;

   state_t     r_state;
   logic       r_gnt_valid;
   logic [2:0] r_gnt_idx;
   logic [3:0] r_outstanding;

   logic       w_win_found;
   logic [2:0] w_win_idx;
   logic       w_resp_ok;
   logic       w_inc;
   logic       w_dec;

`ifdef WBARB_ROUND_ROBIN_EN
   logic [2:0] r_last_gnt;
   logic [7:0] w_cyc_pad;
   logic [3:0] w_cand;

   // Round robin: search upward from the master after the last winner, wrapping at NMASTER
   always_comb begin
      w_cyc_pad              = '0;
      w_cyc_pad[NMASTER-1:0] = m_cyc;
      w_win_found            = 1'b0;
      w_win_idx              = '0;
      w_cand                 = '0;
      for (int k = 1; k <= NMASTER; k++) begin
         w_cand = {1'b0, r_last_gnt} + 4'(k);
         if (w_cand >= 4'(NMASTER)) begin
            w_cand = w_cand - 4'(NMASTER);
         end
         if (!w_win_found && w_cyc_pad[w_cand[2:0]]) begin
            w_win_found = 1'b1;
            w_win_idx   = w_cand[2:0];
         end
      end
   end

   // Pointer starts at the top index so master 0 is searched first after reset
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_last_gnt <= 3'(NMASTER - 1);
      end else if (r_state == ST_IDLE && w_win_found) begin
         r_last_gnt <= w_win_idx;
      end
   end
`else
   // Fixed priority: lowest requesting index wins
   always_comb begin
      w_win_found = |m_cyc;
      w_win_idx   = '0;
      for (int i = NMASTER - 1; i >= 0; i--) begin
         if (m_cyc[i]) begin
            w_win_idx = 3'(i);
         end
      end
   end
`endif

   // Responses are only meaningful while a granted master has requests in flight
   assign w_resp_ok = (r_state == ST_OWNED) && (r_outstanding != 4'd0);
   assign w_inc     = o_stb && !o_stall;
   assign w_dec     = w_resp_ok && (o_ack || o_err);

   // Grant FSM with registered status and the in-flight request counter
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state       <= ST_IDLE;
         r_gnt_valid   <= 1'b0;
         r_gnt_idx     <= '0;
         r_outstanding <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_win_found) begin
                  r_state     <= ST_OWNED;
                  r_gnt_valid <= 1'b1;
                  r_gnt_idx   <= w_win_idx;
               end
            end
            ST_OWNED: begin
               if (!o_cyc) begin
                  // Release abandons any pending responses
                  r_state       <= ST_IDLE;
                  r_gnt_valid   <= 1'b0;
                  r_outstanding <= '0;
               end else if (w_inc && !w_dec) begin
                  if (r_outstanding != 4'hF) begin
                     r_outstanding <= r_outstanding + 4'd1;
                  end
               end else if (w_dec && !w_inc) begin
                  r_outstanding <= r_outstanding - 4'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Route the owner's request to the slave and the slave's response back to the owner only
   always_comb begin
      o_cyc   = 1'b0;
      o_stb   = 1'b0;
      o_we    = 1'b0;
      o_addr  = '0;
      o_data  = '0;
      o_sel   = '0;
      m_stall = '1;
      m_ack   = '0;
      m_err   = '0;
      if (r_state == ST_OWNED) begin
         for (int i = 0; i < NMASTER; i++) begin
            if (r_gnt_idx == 3'(i)) begin
               o_cyc      = m_cyc[i];
               o_stb      = m_stb[i];
               o_we       = m_we[i];
               o_addr     = m_addr[i*AW +: AW];
               o_data     = m_data[i*DW +: DW];
               o_sel      = m_sel[i*SW +: SW];
               m_stall[i] = o_stall;
               m_ack[i]   = o_ack && w_resp_ok;
               m_err[i]   = o_err && w_resp_ok;
            end
         end
      end
   end

   assign gnt_valid   = r_gnt_valid;
   assign gnt_idx     = r_gnt_idx;
   assign outstanding = r_outstanding;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter with a transaction-level model
module tb_wb_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic            CLK = 1'b0;
   logic            nRST;
   logic [N-1:0]    m_cyc, m_stb, m_we;
   logic [N*AW-1:0] m_addr;
   logic [N*DW-1:0] m_data;
   logic [N*SW-1:0] m_sel;
   logic [N-1:0]    m_stall, m_ack, m_err;
   logic            o_cyc, o_stb, o_we;
   logic [AW-1:0]   o_addr;
   logic [DW-1:0]   o_data;
   logic [SW-1:0]   o_sel;
   logic            o_stall, o_ack, o_err;
   logic            gnt_valid;
   logic [2:0]      gnt_idx;
   logic [3:0]      outstanding;

   int checks   = 0;
   int failures = 0;

   // model state: owner index (-1 = nobody), last winner, in-flight count, reported index
   int mo_owner = -1;
   int mo_last  = N - 1;
   int mo_out   = 0;
   int mo_gidx  = 0;
   bit cmp_en   = 1'b0;

   wb_rr_arbiter #(.NMASTER(N), .AW(AW), .DW(DW)) dut (
      .CLK(CLK), .nRST(nRST),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_data(m_data), .m_sel(m_sel),
      .m_stall(m_stall), .m_ack(m_ack), .m_err(m_err),
      .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_data(o_data), .o_sel(o_sel),
      .o_stall(o_stall), .o_ack(o_ack), .o_err(o_err),
      .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .outstanding(outstanding)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick();
      int c;
`ifdef WBARB_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) begin
         c = (mo_last + k) % N;
         if (m_cyc[c]) return c;
      end
`else
      for (int i = 0; i < N; i++) begin
         c = i;
         if (m_cyc[c]) return c;
      end
`endif
      return -1;
   endfunction

   task automatic model_step();
      int  w;
      bit  inc, dec;
      if (!nRST) begin
         mo_owner = -1; mo_last = N - 1; mo_out = 0; mo_gidx = 0;
      end else if (mo_owner < 0) begin
         w = pick();
         if (w >= 0) begin
            mo_owner = w; mo_gidx = w; mo_last = w;
         end
      end else if (!m_cyc[mo_owner]) begin
         mo_owner = -1; mo_out = 0;
      end else begin
         inc = m_stb[mo_owner] && !o_stall;
         dec = (o_ack || o_err) && (mo_out > 0);
         if (inc && !dec && mo_out < 15) mo_out++;
         else if (dec && !inc) mo_out--;
      end
      cmp_en = 1'b1;
   endtask

   task automatic compare();
      logic [N-1:0]  e_stall, e_ack, e_err;
      logic          e_cyc, e_stb, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      logic [SW-1:0] e_sel;
      e_stall = '1; e_ack = '0; e_err = '0;
      e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_data = '0; e_sel = '0;
      if (mo_owner >= 0) begin
         e_cyc  = m_cyc[mo_owner];
         e_stb  = m_stb[mo_owner];
         e_we   = m_we[mo_owner];
         e_addr = m_addr[mo_owner*AW +: AW];
         e_data = m_data[mo_owner*DW +: DW];
         e_sel  = m_sel[mo_owner*SW +: SW];
         e_stall[mo_owner] = o_stall;
         e_ack[mo_owner]   = o_ack && (mo_out > 0);
         e_err[mo_owner]   = o_err && (mo_out > 0);
      end
      chk("cmp_o_cyc", o_cyc, e_cyc);
      chk("cmp_o_stb", o_stb, e_stb);
      chk("cmp_o_we", o_we, e_we);
      chk("cmp_o_addr", o_addr, e_addr);
      chk("cmp_o_data", o_data, e_data);
      chk("cmp_o_sel", o_sel, e_sel);
      chk("cmp_m_stall", m_stall, e_stall);
      chk("cmp_m_ack", m_ack, e_ack);
      chk("cmp_m_err", m_err, e_err);
      chk("cmp_gnt_valid", gnt_valid, (mo_owner >= 0));
      chk("cmp_gnt_idx", gnt_idx, 64'(mo_gidx));
      chk("cmp_outstanding", outstanding, 64'(mo_out));
   endtask

   initial forever begin
      @(posedge CLK);
      model_step();
   end

   initial forever begin
      @(negedge CLK);
      if (cmp_en) compare();
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      nRST = 0;
      m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_data = '0; m_sel = '0;
      o_stall = 0; o_ack = 0; o_err = 0;
      step();
      step();
      nRST = 1;
   endtask

   int exp_ord[5];
   logic [N-1:0] mask;
   int g, n;

   initial begin
      // reset then a single request from master 2
      do_reset();
      settle();
      chk("rst_gnt_valid", gnt_valid, 0);
      chk("rst_gnt_idx", gnt_idx, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_o_cyc", o_cyc, 0);
      chk("rst_m_stall", m_stall, 4'hF);
      m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0100;
      m_addr[2*AW +: AW] = 32'hA000_0020;
      m_data[2*DW +: DW] = 32'hDEAD_BEEF;
      m_sel[2*SW +: SW]  = 4'hF;
      settle();
      chk("single_no_grant_yet", gnt_valid, 0);
      step(); settle();
      chk("single_gnt_valid", gnt_valid, 1);
      chk("single_gnt_idx", gnt_idx, 2);
      chk("single_o_stb", o_stb, 1);
      chk("single_o_addr", o_addr, 32'hA000_0020);
      chk("single_o_data", o_data, 32'hDEAD_BEEF);
      chk("single_m_stall", m_stall, 4'b1011);
      step();
      m_stb = '0; o_ack = 1; settle();
      chk("single_out1", outstanding, 1);
      chk("single_ack_route", m_ack, 4'b0100);
      step();
      o_ack = 0; m_cyc = '0; m_we = '0;
      step(); settle();
      chk("single_released", gnt_valid, 0);

      // simultaneous requesters, each owner releases after one ack
`ifdef WBARB_ROUND_ROBIN_EN
      exp_ord = '{0, 1, 2, 3, 0}; mask = 4'b1111;
`else
      exp_ord = '{1, 1, 1, 1, 1}; mask = 4'b1110;
`endif
      do_reset();
      m_cyc = mask;
      for (int r = 0; r < 5; r++) begin
         n = 0;
         while (gnt_valid !== 1'b1 && n < 10) begin
            step();
            n++;
         end
         settle();
         chk("multi_grant_wait", gnt_valid, 1);
         g = int'(gnt_idx) % N;
         chk("multi_order", gnt_idx, 64'(exp_ord[r]));
         chk("multi_nonowner_stall", m_stall | (4'b1 << g), 4'hF);
         m_stb[g] = 1;
         step();
         m_stb[g] = 0; o_ack = 1; settle();
         chk("multi_ack_route", m_ack, 4'b1 << g);
         step();
         o_ack = 0; m_cyc[g] = 0;
         step();
         m_cyc[g] = 1;
      end
      m_cyc = '0;
      step(); step();

      // pipelined burst, mixed responses, stall, saturation, release with pending
      do_reset();
      m_cyc = 4'b0001;
      step();
      o_ack = 1; settle();
      chk("ack_at_zero_dropped", m_ack, 0);
      o_ack = 0;
      m_stb = 4'b0001;
      step(); settle(); chk("burst_out1", outstanding, 1);
      step(); settle(); chk("burst_out2", outstanding, 2);
      step(); settle(); chk("burst_out3", outstanding, 3);
      m_stb = '0;
      step(); settle(); chk("burst_gap3", outstanding, 3);
      o_ack = 1;
      step(); settle(); chk("burst_ack2", outstanding, 2);
      o_ack = 0; o_err = 1; settle();
      chk("burst_err_route", m_err, 4'b0001);
      step(); settle(); chk("burst_err1", outstanding, 1);
      o_err = 0; m_stb = 4'b0001; o_ack = 1;
      step(); settle(); chk("burst_stb_ack_hold", outstanding, 1);
      m_stb = '0;
      step(); settle(); chk("burst_ack0", outstanding, 0);
      o_ack = 0; m_stb = 4'b0001; o_stall = 1; settle();
      chk("stall_route", m_stall, 4'hF);
      step(); settle(); chk("stall_no_count", outstanding, 0);
      o_stall = 0;
      for (int i = 0; i < 17; i++) step();
      settle(); chk("sat_15", outstanding, 15);
      o_ack = 1;
      step(); settle(); chk("sat_stb_ack_hold", outstanding, 15);
      m_stb = '0;
      step(); settle(); chk("sat_ack14", outstanding, 14);
      o_ack = 0; m_cyc = '0;
      step(); settle();
      chk("release_clears", outstanding, 0);
      chk("release_idle", gnt_valid, 0);

      // abort with two pending, then a late ack in idle
      m_cyc = 4'b0001;
      step();
      m_stb = 4'b0001;
      step(); step(); settle();
      chk("abort_out2", outstanding, 2);
      m_cyc = '0; m_stb = '0;
      step();
      o_ack = 1; settle();
      chk("abort_out0", outstanding, 0);
      chk("abort_no_ack", m_ack, 0);
      chk("abort_o_cyc", o_cyc, 0);
      step();
      o_ack = 0;

      // reset while owned with a strobe active
      m_cyc = 4'b0010; m_stb = 4'b0010;
      step(); settle();
      chk("midrst_o_stb_before", o_stb, 1);
      nRST = 0;
      step(); settle();
      chk("midrst_o_cyc", o_cyc, 0);
      chk("midrst_o_stb", o_stb, 0);
      chk("midrst_gnt_valid", gnt_valid, 0);
      chk("midrst_m_stall", m_stall, 4'hF);
      step(); settle();
      chk("midrst_held_no_grant", gnt_valid, 0);
      nRST = 1; m_cyc = '0; m_stb = '0;
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
